register_file_bypass: RTL and testbench

//  Parametrised 2-read/1-write register file for the RISC core; successor to the fixed 16x32 bank.

---
 rtl/register_file_bypass_if.sv | 30 +++
 rtl/register_file_bypass.sv | 66 ++++++
 tb/tb_register_file_bypass.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/register_file_bypass_if.sv
// register_file_bypass_if: read, write and reserve bus between decode/writeback and the register file
interface register_file_bypass_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH = 32
);
    logic                  rd_en1;
    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic                  rd_en2;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  rsv_en;
    logic [ADDR_WIDTH-1:0] rsv_addr;
    logic [WIDTH-1:0]      dout1;
    logic                  dvalid1;
    logic                  dbusy1;
    logic [WIDTH-1:0]      dout2;
    logic                  dvalid2;
    logic                  dbusy2;

    modport master (
        output rd_en1, rd_addr1, rd_en2, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  dout1, dvalid1, dbusy1, dout2, dvalid2, dbusy2
    );
    modport slave (
        input  rd_en1, rd_addr1, rd_en2, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output dout1, dvalid1, dbusy1, dout2, dvalid2, dbusy2
    );
endinterface

// File: rtl/register_file_bypass.sv
// register_file_bypass: 2-read/1-write register file with registered reads, write bypass,
// optional hardwired-zero R0 and a per-register busy scoreboard
module register_file_bypass #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH = 32,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS = 1
) (
    input logic clk,
    input logic rst_n,
    register_file_bypass_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy, wr_mask, rsv_mask;
    logic             wr_ok, rsv_ok, byp1, byp2, rbusy1, rbusy2;
    logic [WIDTH-1:0] rdata1, rdata2;

    always_comb begin
        wr_ok = bus.wr_en && !(ZERO_R0 != 0 && bus.wr_addr == '0);
        rsv_ok = bus.rsv_en && !(ZERO_R0 != 0 && bus.rsv_addr == '0);
        wr_mask = '0;
        rsv_mask = '0;
        wr_mask[bus.wr_addr] = wr_ok;
        rsv_mask[bus.rsv_addr] = rsv_ok;
        byp1 = BYPASS != 0 && wr_ok && bus.wr_addr == bus.rd_addr1;
        byp2 = BYPASS != 0 && wr_ok && bus.wr_addr == bus.rd_addr2;
        rdata1 = (ZERO_R0 != 0 && bus.rd_addr1 == '0) ? '0 : byp1 ? bus.wr_data : regs[bus.rd_addr1];
        rdata2 = (ZERO_R0 != 0 && bus.rd_addr2 == '0) ? '0 : byp2 ? bus.wr_data : regs[bus.rd_addr2];
        rbusy1 = !byp1 && busy[bus.rd_addr1];
        rbusy2 = !byp2 && busy[bus.rd_addr2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // reserve applied after the write clear so a new producer wins on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else busy <= (busy & ~wr_mask) | rsv_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout1 <= '0;
            bus.dvalid1 <= 1'b0;
            bus.dbusy1 <= 1'b0;
            bus.dout2 <= '0;
            bus.dvalid2 <= 1'b0;
            bus.dbusy2 <= 1'b0;
        end else begin
            bus.dout1 <= bus.rd_en1 ? rdata1 : '0;
            bus.dvalid1 <= bus.rd_en1;
            bus.dbusy1 <= bus.rd_en1 && rbusy1;
            bus.dout2 <= bus.rd_en2 ? rdata2 : '0;
            bus.dvalid2 <= bus.rd_en2;
            bus.dbusy2 <= bus.rd_en2 && rbusy2;
        end
    end
endmodule

// File: tb/tb_register_file_bypass.sv
// tb_register_file_bypass: drives a bypassing file (dut_a) and a zero-R0 non-bypassing file (dut_b)
// with identical traffic and checks both against a register/scoreboard model
module tb_register_file_bypass;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    logic [31:0] mreg [2][16];
    bit          mbusy [2][16];

    register_file_bypass_if #(.ADDR_WIDTH(4), .WIDTH(32)) ia ();
    register_file_bypass_if #(.ADDR_WIDTH(4), .WIDTH(32)) ib ();

    assign ib.rd_en1 = ia.rd_en1;
    assign ib.rd_addr1 = ia.rd_addr1;
    assign ib.rd_en2 = ia.rd_en2;
    assign ib.rd_addr2 = ia.rd_addr2;
    assign ib.wr_en = ia.wr_en;
    assign ib.wr_addr = ia.wr_addr;
    assign ib.wr_data = ia.wr_data;
    assign ib.rsv_en = ia.rsv_en;
    assign ib.rsv_addr = ia.rsv_addr;

    register_file_bypass #(.ADDR_WIDTH(4), .WIDTH(32), .ZERO_R0(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave));
    register_file_bypass #(.ADDR_WIDTH(4), .WIDTH(32), .ZERO_R0(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.slave));

    always #5 clk = ~clk;

    typedef struct {
        bit e1; logic [3:0] a1; bit e2; logic [3:0] a2;
        bit we; logic [3:0] wa; logic [31:0] wd; bit re; logic [3:0] ra;
        logic [31:0] d1; bit v1; bit b1; logic [31:0] d2; bit v2; bit b2;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++) begin
                mreg[d][r] = '0;
                mbusy[d][r] = 1'b0;
            end
    endtask

    task automatic step(input bit e1, input logic [3:0] a1, input bit e2, input logic [3:0] a2,
                        input bit we, input logic [3:0] wa, input logic [31:0] wd,
                        input bit re, input logic [3:0] ra);
        bit en [2];
        logic [3:0] ad [2];
        logic [31:0] ed [2][2];
        bit ev [2][2];
        bit eb [2][2];
        ia.rd_en1 = e1; ia.rd_addr1 = a1; ia.rd_en2 = e2; ia.rd_addr2 = a2;
        ia.wr_en = we; ia.wr_addr = wa; ia.wr_data = wd; ia.rsv_en = re; ia.rsv_addr = ra;
        en[0] = e1; en[1] = e2; ad[0] = a1; ad[1] = a2;
        // d=0: plain R0, same-cycle writes forwarded; d=1: R0 reads zero, no forwarding
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                ev[d][p] = en[p];
                ed[d][p] = '0;
                eb[d][p] = 1'b0;
                if (en[p] && !(d == 1 && ad[p] == 0)) begin
                    if (d == 0 && we && wa == ad[p]) ed[d][p] = wd;
                    else begin
                        ed[d][p] = mreg[d][ad[p]];
                        eb[d][p] = mbusy[d][ad[p]];
                    end
                end
            end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (we && !(d == 1 && wa == 0)) begin
                mreg[d][wa] = wd;
                mbusy[d][wa] = 1'b0;
            end
            if (re && !(d == 1 && ra == 0)) mbusy[d][ra] = 1'b1;
        end
        #1;
        chk("a.dout1", ia.dout1, ed[0][0]);
        chk("a.dvalid1", 32'(ia.dvalid1), 32'(ev[0][0]));
        chk("a.dbusy1", 32'(ia.dbusy1), 32'(eb[0][0]));
        chk("a.dout2", ia.dout2, ed[0][1]);
        chk("a.dvalid2", 32'(ia.dvalid2), 32'(ev[0][1]));
        chk("a.dbusy2", 32'(ia.dbusy2), 32'(eb[0][1]));
        chk("b.dout1", ib.dout1, ed[1][0]);
        chk("b.dvalid1", 32'(ib.dvalid1), 32'(ev[1][0]));
        chk("b.dbusy1", 32'(ib.dbusy1), 32'(eb[1][0]));
        chk("b.dout2", ib.dout2, ed[1][1]);
        chk("b.dvalid2", 32'(ib.dvalid2), 32'(ev[1][1]));
        chk("b.dbusy2", 32'(ib.dbusy2), 32'(eb[1][1]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " a.dout1"}, ia.dout1, 0);
        chk({tag, " a.dvalid1"}, 32'(ia.dvalid1), 0);
        chk({tag, " a.dbusy2"}, 32'(ia.dbusy2), 0);
        chk({tag, " b.dout1"}, ib.dout1, 0);
        chk({tag, " b.dvalid2"}, 32'(ib.dvalid2), 0);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 7, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 7, 1, 7, 1, 7, 32'hAA, 0, 0, 32'hAA, 1, 0, 32'hAA, 1, 0};
        tbl[4]  = '{1, 7, 1, 7, 0, 0, 0, 0, 0, 32'hAA, 1, 0, 32'hAA, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 9, 1, 9, 32'h55, 1, 9, 0, 0, 0, 32'h55, 1, 0};
        tbl[8]  = '{1, 9, 0, 0, 0, 0, 0, 0, 0, 32'h55, 1, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 9, 1, 9, 32'h66, 0, 0, 0, 0, 0, 32'h66, 1, 0};
        tbl[10] = '{1, 9, 1, 3, 0, 0, 0, 0, 0, 32'h66, 1, 0, 32'h12345678, 1, 0};
        tbl[11] = '{0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 1, 1};

        ia.rd_en1 = 0; ia.rd_addr1 = 0; ia.rd_en2 = 0; ia.rd_addr2 = 0;
        ia.wr_en = 0; ia.wr_addr = 0; ia.wr_data = 0; ia.rsv_en = 0; ia.rsv_addr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].e1, tbl[i].a1, tbl[i].e2, tbl[i].a2, tbl[i].we, tbl[i].wa, tbl[i].wd,
                 tbl[i].re, tbl[i].ra);
            chk($sformatf("vec%0d dout1", i), ia.dout1, tbl[i].d1);
            chk($sformatf("vec%0d dvalid1", i), 32'(ia.dvalid1), 32'(tbl[i].v1));
            chk($sformatf("vec%0d dbusy1", i), 32'(ia.dbusy1), 32'(tbl[i].b1));
            chk($sformatf("vec%0d dout2", i), ia.dout2, tbl[i].d2);
            chk($sformatf("vec%0d dvalid2", i), 32'(ia.dvalid2), 32'(tbl[i].v2));
            chk($sformatf("vec%0d dbusy2", i), 32'(ia.dbusy2), 32'(tbl[i].b2));
            if (i == 3) chk("nobyp old R7", ib.dout2, 32'h1);
            if (i == 4) chk("nobyp new R7", ib.dout1, 32'hAA);
            if (i == 13) begin
                chk("zero R0 dout", ib.dout1, 0);
                chk("zero R0 dbusy", 32'(ib.dbusy2), 0);
            end
        end

        // asynchronous reset between edges clears the held read immediately
        step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        step(1, 5, 1, 5, 0, 0, 0, 1, 5);
        chk("pre-reset R5", ia.dout1, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1 chk_zero("async reset");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        step(1, 5, 1, 5, 0, 0, 0, 0, 0);
        chk("R5 after reset", ia.dout1, 0);
        chk("R5 valid after reset", 32'(ia.dvalid1), 1);
        chk("R5 busy after reset", 32'(ia.dbusy2), 0);

        for (int n = 0; n < 600; n++) begin
            logic [3:0] lim;
            lim = (n % 2 == 0) ? 4'd3 : 4'd15;
            step(1'($urandom), 4'($urandom_range(0, int'(lim))), 1'($urandom),
                 4'($urandom_range(0, int'(lim))), 1'($urandom), 4'($urandom_range(0, int'(lim))),
                 $urandom, 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, int'(lim))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
